// File: rtl/lcd_spi_master.sv
// Write-only 4-wire SPI master (mode 0, MSB first) for the 160x80 LCD panel.
// Each start pulse sends one command byte (dc=0) followed by 0..4 data
// bytes (dc=1). All pins are driven straight from registers.
module lcd_spi_master #(
  parameter int CLK_DIV      = 2,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_start_cmd,
  input  logic [2:0] spi_mode,
  input  logic [7:0] cmd_spi_cmd,
  input  logic [7:0] cmd_spi_data1,
  input  logic [7:0] cmd_spi_data2,
  input  logic [7:0] cmd_spi_data3,
  input  logic [7:0] cmd_spi_data4,
  input  logic [3:0] cmd_spi_data_num,
  output logic       spi_busy,
  output logic       spi_done,
  output logic       lcd_cs_n,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_dc
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    CS_HOLD  = 2'd3
  } state_t;

  // Terminal counts: each phase lasts (count + 1) cycles.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD_CYC - 1);

  state_t      state_r, state_s;
  logic [7:0]  div_cnt_r, div_cnt_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [2:0]  byte_cnt_r, byte_cnt_s;
  logic [2:0]  nbytes_r, nbytes_s;
  logic [39:0] shreg_r, shreg_s;
  logic        cs_n_r, cs_n_s;
  logic        sclk_r, sclk_s;
  logic        mosi_r, mosi_s;
  logic        dc_r, dc_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;

  // Number of data bytes to send: none in command-only mode, else clamped to 4.
  function automatic logic [2:0] data_bytes(input logic [2:0] mode, input logic [3:0] num);
    logic [2:0] n;
    if (mode == 3'd0) begin
      n = 3'd0;
    end else if (num > 4'd4) begin
      n = 3'd4;
    end else begin
      n = num[2:0];
    end
    return n;
  endfunction

  // Next-state and next-output logic; everything holds unless a phase ends.
  always_comb begin
    state_s    = state_r;
    div_cnt_s  = div_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    byte_cnt_s = byte_cnt_r;
    nbytes_s   = nbytes_r;
    shreg_s    = shreg_r;
    cs_n_s     = cs_n_r;
    sclk_s     = sclk_r;
    mosi_s     = mosi_r;
    dc_s       = dc_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (spi_start_cmd) begin
          // The whole frame is latched so later input changes are harmless.
          shreg_s    = {cmd_spi_cmd, cmd_spi_data1, cmd_spi_data2,
                        cmd_spi_data3, cmd_spi_data4};
          nbytes_s   = data_bytes(spi_mode, cmd_spi_data_num);
          div_cnt_s  = 8'd0;
          bit_cnt_s  = 3'd0;
          byte_cnt_s = 3'd0;
          cs_n_s     = 1'b0;
          busy_s     = 1'b1;
          dc_s       = 1'b0;
          mosi_s     = cmd_spi_cmd[7];
          state_s    = CS_SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      CS_SETUP: begin
        if (div_cnt_r == SETUP_LAST) begin
          div_cnt_s = 8'd0;
          state_s   = SHIFT;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end
      SHIFT: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_s = 8'd0;
          if (!sclk_r) begin
            sclk_s = 1'b1;
          end else begin
            // Falling edge: advance mosi (and dc at a byte boundary) now,
            // so nothing changes while sclk is high.
            sclk_s = 1'b0;
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_s = 3'd0;
              if (byte_cnt_r == nbytes_r) begin
                state_s = CS_HOLD;
              end else begin
                byte_cnt_s = byte_cnt_r + 3'd1;
                dc_s       = 1'b1;
                mosi_s     = shreg_r[38];
                shreg_s    = {shreg_r[38:0], 1'b0};
              end
            end else begin
              bit_cnt_s = bit_cnt_r + 3'd1;
              mosi_s    = shreg_r[38];
              shreg_s   = {shreg_r[38:0], 1'b0};
            end
          end
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end
      CS_HOLD: begin
        if (div_cnt_r == HOLD_LAST) begin
          div_cnt_s  = 8'd0;
          bit_cnt_s  = 3'd0;
          byte_cnt_s = 3'd0;
          cs_n_s     = 1'b1;
          busy_s     = 1'b0;
          dc_s       = 1'b0;
          mosi_s     = 1'b0;
          done_s     = 1'b1;
          state_s    = IDLE;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end
      default: begin
        div_cnt_s  = 8'd0;
        bit_cnt_s  = 3'd0;
        byte_cnt_s = 3'd0;
        cs_n_s     = 1'b1;
        sclk_s     = 1'b0;
        busy_s     = 1'b0;
        dc_s       = 1'b0;
        mosi_s     = 1'b0;
        state_s    = IDLE;
      end
    endcase
  end

  // State, counters and output registers; reset forces idle pin levels at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      div_cnt_r  <= 8'd0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 3'd0;
      nbytes_r   <= 3'd0;
      shreg_r    <= 40'd0;
      cs_n_r     <= 1'b1;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      dc_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      nbytes_r   <= nbytes_s;
      shreg_r    <= shreg_s;
      cs_n_r     <= cs_n_s;
      sclk_r     <= sclk_s;
      mosi_r     <= mosi_s;
      dc_r       <= dc_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign spi_busy = busy_r;
  assign spi_done = done_r;
  assign lcd_cs_n = cs_n_r;
  assign lcd_sclk = sclk_r;
  assign lcd_mosi = mosi_r;
  assign lcd_dc   = dc_r;

endmodule

// File: tb/tb_lcd_spi_master.sv
// Bench for lcd_spi_master: a cycle-level waveform model derived from the
// transaction timing rules, checked every cycle, plus literal expectations
// on captured SPI bytes, busy length and CS gaps.
module tb_lcd_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] cmd = 8'h00, d1 = 8'h00, d2 = 8'h00, d3 = 8'h00, d4 = 8'h00;
  logic [3:0] num = 4'd0;

  logic busy_a, done_a, cs_a, sclk_a, mosi_a, dc_a;
  logic busy_b, done_b, cs_b, sclk_b, mosi_b, dc_b;

  int total = 0;
  int bad = 0;
  int ecnt = 0;
  logic chk_en = 1'b0;

  // model state per DUT (0 = defaults, 1 = all timing params 1)
  logic        act [2];
  int          t0 [2];
  int          ntot [2];
  int          nb [2];
  logic [39:0] bits_m [2];

  logic [1:0] rq_a[$];
  logic [1:0] rq_b[$];

  always #5 clk = ~clk;

  lcd_spi_master dut_a (
    .clk(clk), .rst_n(rst_n), .spi_start_cmd(start_a), .spi_mode(mode),
    .cmd_spi_cmd(cmd), .cmd_spi_data1(d1), .cmd_spi_data2(d2),
    .cmd_spi_data3(d3), .cmd_spi_data4(d4), .cmd_spi_data_num(num),
    .spi_busy(busy_a), .spi_done(done_a), .lcd_cs_n(cs_a),
    .lcd_sclk(sclk_a), .lcd_mosi(mosi_a), .lcd_dc(dc_a)
  );

  lcd_spi_master #(.CLK_DIV(1), .CS_SETUP_CYC(1), .CS_HOLD_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_start_cmd(start_b), .spi_mode(mode),
    .cmd_spi_cmd(cmd), .cmd_spi_data1(d1), .cmd_spi_data2(d2),
    .cmd_spi_data3(d3), .cmd_spi_data4(d4), .cmd_spi_data_num(num),
    .spi_busy(busy_b), .spi_done(done_b), .lcd_cs_n(cs_b),
    .lcd_sclk(sclk_b), .lcd_mosi(mosi_b), .lcd_dc(dc_b)
  );

  function automatic int p_setup(input int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int p_div(input int d);   return (d == 0) ? 2 : 1; endfunction
  function automatic int p_hold(input int d);  return (d == 0) ? 2 : 1; endfunction
  function automatic int nbytes_of(input logic [2:0] md, input logic [3:0] n);
    if (md == 3'd0) return 0;
    if (n > 4'd4) return 4;
    return int'(n);
  endfunction
  function automatic logic strt(input int d); return (d == 0) ? start_a : start_b; endfunction

  // Model: a start is accepted on an edge where the device is idle, i.e. never
  // before one full idle cycle has followed the previous transaction's end.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act[0] <= 1'b0;
      act[1] <= 1'b0;
    end else begin
      ecnt <= ecnt + 1;
      for (int d = 0; d < 2; d++) begin
        if (strt(d) && (!act[d] || ecnt >= t0[d] + ntot[d] + 1)) begin
          act[d]    <= 1'b1;
          t0[d]     <= ecnt;
          nb[d]     <= nbytes_of(mode, num);
          bits_m[d] <= {cmd, d1, d2, d3, d4};
          ntot[d]   <= p_setup(d) + 16 * p_div(d) * (1 + nbytes_of(mode, num)) + p_hold(d);
        end
      end
    end
  end

  // Expected {cs_n,sclk,mosi,dc,busy,done} for the current cycle, returned as {mask,value}.
  function automatic logic [11:0] exp_vec(input int d);
    int k, s, b, dv, sh;
    logic [5:0] e, m;
    dv = p_div(d);
    sh = 16 * dv * (1 + nb[d]);
    k  = ecnt - 1 - t0[d];
    m  = 6'b111111;
    e  = 6'b100000;
    if (act[d] && k >= 0 && k < ntot[d]) begin
      s = k - p_setup(d);
      b = (s < 0) ? 0 : s / (2 * dv);
      e[5] = 1'b0;
      e[4] = (s >= 0 && s < sh) ? (((s / dv) % 2) == 1) : 1'b0;
      e[1] = 1'b1;
      e[0] = 1'b0;
      if (s < sh) begin
        e[3] = bits_m[d][39 - b];
        e[2] = (b >= 8);
      end else begin
        m[3] = 1'b0;
        m[2] = 1'b0;
      end
    end else if (act[d] && k == ntot[d]) begin
      e = 6'b100001;
    end
    return {m, e};
  endfunction

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [11:0] me;
        logic [5:0] got;
        me  = exp_vec(d);
        got = (d == 0) ? {cs_a, sclk_a, mosi_a, dc_a, busy_a, done_a}
                       : {cs_b, sclk_b, mosi_b, dc_b, busy_b, done_b};
        total++;
        if ((got & me[11:6]) !== (me[5:0] & me[11:6])) begin
          bad++;
          $display("FAIL cycle_model dut=%0d edge=%0d got=%b expected=%b mask=%b",
                   d, ecnt - 1, got, me[5:0], me[11:6]);
        end
      end
    end
  end

  // Capture {dc,mosi} at every SCLK rise, as the panel would.
  always @(posedge sclk_a) rq_a.push_back({dc_a, mosi_a});
  always @(posedge sclk_b) rq_b.push_back({dc_b, mosi_b});

  task automatic chk(input string nm, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  // Check captured bytes against a literal stream: byte 0 with dc=0, rest dc=1.
  task automatic check_rises(input int d, input int nbytes, input logic [39:0] stream,
                             input string nm);
    logic [1:0] q[$];
    logic [7:0] byt, expb;
    if (d == 0) q = rq_a; else q = rq_b;
    chk({nm, "_rises"}, q.size(), 8 * nbytes);
    if (q.size() == 8 * nbytes) begin
      for (int j = 0; j < nbytes; j++) begin
        int dcbad;
        dcbad = 0;
        for (int i = 0; i < 8; i++) begin
          byt[7 - i] = q[8 * j + i][0];
          if (q[8 * j + i][1] !== (j > 0)) dcbad++;
        end
        expb = stream[39 - 8 * j -: 8];
        chk({nm, "_byte"}, int'(byt), int'(expb));
        chk({nm, "_dc_errs"}, dcbad, 0);
      end
    end
  endtask

  // One transaction: start pulse, scramble inputs after latch, optional
  // stray start pulse at cycle 'poke', wait (bounded) for done.
  task automatic do_txn(input int d, input logic [2:0] md, input logic [7:0] c,
                        input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
                        input logic [7:0] a4, input logic [3:0] n, input int poke,
                        output int bc, output int hc);
    bit found;
    rq_a.delete();
    rq_b.delete();
    @(negedge clk);
    mode = md; cmd = c; d1 = a1; d2 = a2; d3 = a3; d4 = a4; num = n;
    if (d == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    cmd = ~c; d1 = ~a1; d2 = ~a2; d3 = ~a3; d4 = ~a4; num = 4'd0; mode = ~md;
    bc = 0; hc = 0; found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == poke) begin
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if ((d == 0) ? busy_a : busy_b) bc++;
      if ((d == 0) ? sclk_a : sclk_b) hc++;
      if ((d == 0) ? done_a : done_b) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start_a = 1'b0; start_b = 1'b0;
    chk("done_seen", int'(found), 1);
  endtask

  initial begin
    int bc, hc, dones, run, gaps, gapbad;
    bit seen_low;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_cs_n", int'(cs_a), 1);
    chk("reset_sclk", int'(sclk_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_mosi_dc", int'({mosi_a, dc_a}), 0);

    // command only, 0x01
    do_txn(0, 3'd0, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 4'd0, -1, bc, hc);
    chk("cmd_only_busy", bc, 36);
    chk("cmd_only_sclk_high", hc, 16);
    check_rises(0, 1, {8'h01, 32'h0}, "cmd01");

    // command + 4 data bytes
    do_txn(0, 3'd1, 8'h2A, 8'h00, 8'h1A, 8'h00, 8'h6A, 4'd4, -1, bc, hc);
    chk("caset_busy", bc, 164);
    check_rises(0, 5, 40'h2A_00_1A_00_6A, "caset");

    // clamping and command-only selection
    do_txn(0, 3'd1, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 4'd7, -1, bc, hc);
    chk("num7_busy", bc, 164);
    check_rises(0, 5, 40'hC3_11_22_33_44, "num7");
    do_txn(0, 3'd1, 8'h81, 8'h55, 8'h66, 8'h77, 8'h88, 4'd0, -1, bc, hc);
    chk("num0_busy", bc, 36);
    check_rises(0, 1, {8'h81, 32'h0}, "num0");
    do_txn(0, 3'd0, 8'h7E, 8'h55, 8'h66, 8'h77, 8'h88, 4'd4, -1, bc, hc);
    chk("mode0_busy", bc, 36);
    check_rises(0, 1, {8'h7E, 32'h0}, "mode0");

    // stray start while busy is ignored
    do_txn(0, 3'd0, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 10, bc, hc);
    chk("stray_busy", bc, 36);
    repeat (4) @(negedge clk);
    chk("stray_no_restart", int'(busy_a), 0);
    check_rises(0, 1, {8'h3C, 32'h0}, "stray");

    // start held high across three transactions
    rq_a.delete();
    @(negedge clk);
    mode = 3'd0; cmd = 8'h5A; num = 4'd0;
    start_a = 1'b1;
    dones = 0; run = 0; gaps = 0; gapbad = 0; seen_low = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cs_a) begin
        if (seen_low) run++;
      end else begin
        if (run > 0) begin
          gaps++;
          if (run != 1) gapbad++;
        end
        run = 0;
        seen_low = 1'b1;
      end
      if (done_a) dones++;
      if (dones == 3) begin
        start_a = 1'b0;
        break;
      end
    end
    start_a = 1'b0;
    chk("held_dones", dones, 3);
    chk("held_gaps", gaps, 2);
    chk("held_gap_len_errs", gapbad, 0);
    chk("held_rises", rq_a.size(), 24);
    repeat (3) @(negedge clk);

    // reset in the middle of the second byte of a 5-byte transfer
    @(negedge clk);
    mode = 3'd1; cmd = 8'h2B; d1 = 8'hF0; d2 = 8'h0F; d3 = 8'hAA; d4 = 8'h55; num = 4'd4;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    chk("pre_reset_sclk", int'(sclk_a), 1);
    chk("pre_reset_busy", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_cs_n", int'(cs_a), 1);
    chk("mid_reset_sclk", int'(sclk_a), 0);
    chk("mid_reset_busy", int'(busy_a), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    do_txn(0, 3'd1, 8'h2C, 8'h77, 8'h00, 8'h00, 8'h00, 4'd1, -1, bc, hc);
    chk("post_reset_busy", bc, 68);
    check_rises(0, 2, {16'h2C77, 24'h0}, "post_reset");

    // minimum timing parameters
    do_txn(1, 3'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, -1, bc, hc);
    chk("fast_busy", bc, 18);
    chk("fast_sclk_high", hc, 8);
    check_rises(1, 1, {8'hA5, 32'h0}, "fast");

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
